// File: rtl/ariane_pkg.sv
// Shared frontend types: resolved-branch bus, BHT prediction record and
// the 2-bit counter type used by branch_history_table.
package ariane_pkg;

  typedef enum logic [2:0] {
    NoCF   = 3'd0,
    Branch = 3'd1,
    Jump   = 3'd2,
    JumpR  = 3'd3,
    Return = 3'd4
  } cf_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [63:0] target_address;
    logic        is_mispredict;
    logic        is_taken;
    cf_t         cf_type;
  } bp_resolve_t;

  typedef struct packed {
    logic valid;
    logic taken;
  } bht_prediction_t;

  typedef logic [1:0] bht_cnt_t;

  localparam bht_cnt_t BHT_CNT_INIT = 2'b01;

  function automatic logic bht_cnt_taken(input bht_cnt_t cnt);
    return cnt[1];
  endfunction

endpackage

// File: rtl/sat_counter_2b.sv
// Next value of a 2-bit saturating counter: increments on taken, decrements
// on not-taken, holding at 11 and 00.
module sat_counter_2b
  import ariane_pkg::*;
(
  input  bht_cnt_t cnt_i,
  input  logic     taken_i,
  output bht_cnt_t cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != 2'b11) cnt_o = cnt_i + 2'b01;
      else                cnt_o = cnt_i;
    end else begin
      if (cnt_i != 2'b00) cnt_o = cnt_i - 2'b01;
      else                cnt_o = cnt_i;
    end
  end

endmodule

// File: rtl/branch_history_table.sv
// Branch history table of 2-bit counters with an init sweep after reset/flush.
// Define BHT_BYPASS_EN for write-first forwarding on same-index update+lookup.
module branch_history_table
  import ariane_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = 1024
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            debug_mode_i,
  input  logic [63:0]     vpc_i,
  input  bp_resolve_t     resolved_branch_i,
  output bht_prediction_t bht_prediction_o,
  output logic            ready_o
);

  localparam int unsigned      IDX_W    = $clog2(NR_ENTRIES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NR_ENTRIES - 1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] init_idx_q;
  bht_prediction_t  pred_q;
  logic             ready_q;
  bht_cnt_t         table_q [NR_ENTRIES];

  logic [IDX_W-1:0] upd_idx;
  logic [IDX_W-1:0] lkp_idx;
  logic             upd_en;
  bht_cnt_t         upd_cnt_d;
  bht_cnt_t         lkp_cnt;
  logic             unused_bits;

  // Index at 2-byte granularity; no tags, so aliasing is accepted.
  assign upd_idx = resolved_branch_i.pc[IDX_W:1];
  assign lkp_idx = vpc_i[IDX_W:1];

  assign upd_en = (state_q == ST_READY) && resolved_branch_i.valid &&
                  (resolved_branch_i.cf_type == Branch) && !debug_mode_i && !flush_i;

  assign unused_bits = ^{vpc_i[63:IDX_W+1], vpc_i[0],
                         resolved_branch_i.pc[63:IDX_W+1], resolved_branch_i.pc[0],
                         resolved_branch_i.target_address, resolved_branch_i.is_mispredict};

  sat_counter_2b u_sat_counter (
    .cnt_i   (table_q[upd_idx]),
    .taken_i (resolved_branch_i.is_taken),
    .cnt_o   (upd_cnt_d)
  );

  always_comb begin
    lkp_cnt = table_q[lkp_idx];
`ifdef BHT_BYPASS_EN
    if (upd_en && (upd_idx == lkp_idx)) lkp_cnt = upd_cnt_d;
    else                                lkp_cnt = table_q[lkp_idx];
`endif
  end

  // Counter storage is plain flops; contents are defined only once the sweep completes.
  always_ff @(posedge clk_i) begin
    if (!flush_i) begin
      if (state_q == ST_INIT) table_q[init_idx_q] <= BHT_CNT_INIT;
      else if (upd_en)        table_q[upd_idx]    <= upd_cnt_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
      pred_q     <= '0;
      ready_q    <= 1'b0;
    end else if (flush_i) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
      pred_q     <= '0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          pred_q <= '0;
          if (init_idx_q == IDX_LAST) begin
            state_q    <= ST_READY;
            init_idx_q <= '0;
            ready_q    <= 1'b1;
          end else begin
            init_idx_q <= init_idx_q + IDX_W'(1);
          end
        end
        ST_READY: begin
          pred_q.valid <= 1'b1;
          pred_q.taken <= bht_cnt_taken(lkp_cnt);
          ready_q      <= 1'b1;
        end
        default: begin
          state_q    <= ST_INIT;
          init_idx_q <= '0;
          pred_q     <= '0;
          ready_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bht_prediction_o = pred_q;
  assign ready_o          = ready_q;

endmodule

// File: tb/tb_branch_history_table.sv
// Self-checking bench for branch_history_table (NR_ENTRIES=16): vector table,
// randomized traffic against an integer reference model, and reset/flush sequences.
module tb_branch_history_table;
  import ariane_pkg::*;

  localparam int N = 16;
`ifdef BHT_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            dbg = 1'b0;
  logic [63:0]     vpc = '0;
  bp_resolve_t     rb = '0;
  bht_prediction_t pred;
  logic            ready;

  branch_history_table #(.NR_ENTRIES(N)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .flush_i           (flush),
    .debug_mode_i      (dbg),
    .vpc_i             (vpc),
    .resolved_branch_i (rb),
    .bht_prediction_o  (pred),
    .ready_o           (ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int m_cnt [N];
  int m_left = N;

  typedef struct {
    logic        fl;
    logic        dbg;
    logic [63:0] vpc;
    logic        rv;
    logic [63:0] rpc;
    logic        rtk;
    cf_t         cft;
    logic [2:0]  exp;   // {valid, taken, ready}
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [2:0] got, input logic [2:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got valid/taken/ready=%b required %b", name, $time, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [63:0] pc);
    return int'((pc >> 1) % 64'(N));
  endfunction

  // One clock: drive inputs, advance the model, compare outputs #1 after the edge.
  task automatic cycle(input logic fl, input logic d, input logic [63:0] pc,
                       input logic rv, input logic [63:0] rpc, input logic rtk,
                       input cf_t cft, output logic [2:0] got);
    logic [2:0] exp;
    int li, ui, pre, nxt;
    logic upd;
    flush = fl; dbg = d; vpc = pc;
    rb = '0; rb.valid = rv; rb.pc = rpc; rb.is_taken = rtk; rb.cf_type = cft;
    li = idx_of(pc); ui = idx_of(rpc);
    if (fl) begin
      exp = 3'b000; m_left = N;
    end else if (m_left > 0) begin
      m_left--;
      exp = {2'b00, (m_left == 0)};
      if (m_left == 0) for (int i = 0; i < N; i++) m_cnt[i] = 1;
    end else begin
      upd = rv && (cft == Branch) && !d;
      pre = m_cnt[li];
      nxt = m_cnt[ui];
      if (upd) begin
        nxt = rtk ? ((nxt < 3) ? nxt + 1 : 3) : ((nxt > 0) ? nxt - 1 : 0);
        m_cnt[ui] = nxt;
      end
      if (BYP && upd && (ui == li)) exp = {1'b1, (nxt >= 2), 1'b1};
      else                          exp = {1'b1, (pre >= 2), 1'b1};
    end
    @(posedge clk);
    #1;
    got = {pred.valid, pred.taken, ready};
    check("model", got, exp);
  endtask

  task automatic idle(input logic [63:0] pc, output logic [2:0] got);
    cycle(1'b0, 1'b0, pc, 1'b0, 64'h0, 1'b0, NoCF, got);
  endtask

  function automatic void add(input logic fl, input logic d, input logic [63:0] pc,
                              input logic rv, input logic [63:0] rpc, input logic rtk,
                              input cf_t cft, input logic [2:0] exp);
    vec_t v;
    v.fl = fl; v.dbg = d; v.vpc = pc; v.rv = rv; v.rpc = rpc; v.rtk = rtk;
    v.cft = cft; v.exp = exp;
    vecs.push_back(v);
  endfunction

  localparam logic [63:0] P0  = 64'h8000_0000;
  localparam logic [63:0] P1E = 64'h8000_001E;
  localparam logic [63:0] P4  = 64'h8000_0004;
  localparam logic [63:0] P6  = 64'h8000_0006;
  localparam logic [63:0] P24 = 64'h8000_0024;
  localparam logic [63:0] PA  = 64'h8000_000A;

  initial begin
    logic [2:0] got;
    for (int i = 0; i < N; i++) m_cnt[i] = 1;

    // Test-plan vectors applied right after the first sweep.
    add(1'b0, 1'b0, P0,  1'b0, 64'h0, 1'b0, NoCF,   3'b101);
    add(1'b0, 1'b0, P1E, 1'b0, 64'h0, 1'b0, NoCF,   3'b101);
    add(1'b0, 1'b0, P0,  1'b1, 64'h4, 1'b1, JumpR,  3'b101);
    add(1'b0, 1'b1, 64'h10, 1'b1, 64'h4, 1'b1, Branch, 3'b101);
    add(1'b0, 1'b0, 64'h4, 1'b0, 64'h0, 1'b0, NoCF, 3'b101);
    add(1'b0, 1'b0, P6,  1'b1, P4, 1'b1, Branch,    3'b101);
    add(1'b0, 1'b0, P0,  1'b1, P4, 1'b1, Branch,    3'b101);
    add(1'b0, 1'b0, P4,  1'b0, 64'h0, 1'b0, NoCF,   3'b111);
    add(1'b0, 1'b0, P0,  1'b1, P4, 1'b1, Branch,    3'b101);
    add(1'b0, 1'b0, P24, 1'b0, 64'h0, 1'b0, NoCF,   3'b111);
    add(1'b0, 1'b0, P6,  1'b0, 64'h0, 1'b0, NoCF,   3'b101);
    add(1'b0, 1'b0, P0,  1'b1, P4, 1'b0, Branch,    3'b101);
    add(1'b0, 1'b0, P0,  1'b1, P4, 1'b0, Branch,    3'b101);
    add(1'b0, 1'b0, P4,  1'b0, 64'h0, 1'b0, NoCF,   3'b101);
    add(1'b0, 1'b0, P0,  1'b1, P4, 1'b0, Branch,    3'b101);
    add(1'b0, 1'b0, P0,  1'b1, P4, 1'b0, Branch,    3'b101);
    add(1'b0, 1'b0, P0,  1'b1, P4, 1'b1, Branch,    3'b101);
    add(1'b0, 1'b0, P4,  1'b0, 64'h0, 1'b0, NoCF,   3'b101);
    add(1'b0, 1'b0, PA,  1'b1, PA, 1'b1, Branch,    {1'b1, BYP, 1'b1});
    add(1'b0, 1'b0, PA,  1'b0, 64'h0, 1'b0, NoCF,   3'b111);
    add(1'b1, 1'b0, P4,  1'b1, P4, 1'b1, Branch,    3'b000);
    for (int i = 0; i < N; i++)
      add(1'b0, 1'b0, P4, 1'b1, P4, 1'b1, Branch, {2'b00, (i == N - 1)});
    add(1'b0, 1'b0, P4,  1'b0, 64'h0, 1'b0, NoCF,   3'b101);
    add(1'b0, 1'b0, P24, 1'b0, 64'h0, 1'b0, NoCF,   3'b101);

    // Reset state, then release between edges.
    #12;
    check("reset_state", {pred.valid, pred.taken, ready}, 3'b000);
    #11 rst = 1'b0;
    m_left = N;
    for (int i = 0; i < N; i++) begin
      idle(P0, got);
      check("init_ready", got, {2'b00, (i == N - 1)});
    end

    foreach (vecs[k]) begin
      cycle(vecs[k].fl, vecs[k].dbg, vecs[k].vpc, vecs[k].rv, vecs[k].rpc,
            vecs[k].rtk, vecs[k].cft, got);
      check($sformatf("vec%0d", k), got, vecs[k].exp);
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(63) == 0), ($urandom_range(7) == 0),
            {$urandom, $urandom}, $urandom_range(1), {$urandom, $urandom},
            $urandom_range(1), cf_t'($urandom_range(4)), got);
    end

    // Drive every entry to strong taken, then flush twice with a restart at step 7.
    for (int i = 0; i < N + 2; i++) idle(P0, got);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++)
        cycle(1'b0, 1'b0, P0, 1'b1, P0 + 64'(2 * i), 1'b1, Branch, got);
    cycle(1'b1, 1'b0, P0, 1'b0, 64'h0, 1'b0, NoCF, got);
    for (int i = 0; i < 7; i++) idle(P0, got);
    cycle(1'b1, 1'b0, P0, 1'b0, 64'h0, 1'b0, NoCF, got);
    for (int i = 0; i < N; i++) begin
      idle(P0, got);
      check("flush_ready", {1'b0, got[0]}, {1'b0, (i == N - 1)});
    end
    for (int i = 0; i < N; i++) begin
      idle(P0 + 64'(2 * i), got);
      check($sformatf("flush_entry%0d", i), got, 3'b101);
    end

    // Asynchronous reset pulse between edges clears outputs immediately.
    idle(P0, got);
    #2 rst = 1'b1;
    #1 check("async_rst", {pred.valid, pred.taken, ready}, 3'b000);
    #1 rst = 1'b0;
    m_left = N;
    for (int i = 0; i < N; i++) idle(P4, got);
    idle(P4, got);
    check("post_rst_lookup", got, 3'b101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
